// File: rtl/rx_fifo.sv
// Receive FIFO: DEPTH x DATA_WIDTH circular buffer, first-word fall-through read port.
// Latency: a write into an empty FIFO shows on r_data right after its clock edge.
// Backpressure: writes while full and reads while empty are dropped; RX_FIFO_ERROR_FLAGS_EN adds sticky overflow/underflow.
module rx_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  w_enable,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_enable,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
`ifdef RX_FIFO_ERROR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance looks only at the registered flags, so a pop never frees room for a same-cycle push.
    assign wr_acc = w_enable && !full;
    assign rd_acc = r_enable && !empty;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign r_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= w_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef RX_FIFO_ERROR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_enable && full) begin
                overflow <= 1'b1;
            end
            if (r_enable && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed and randomised checks of rx_fifo (DEPTH=8, DATA_WIDTH=8) against hand-derived values and a queue model.
// Error-flag checks are compiled in only when RX_FIFO_ERROR_FLAGS_EN is defined.
module tb_rx_fifo;

    logic       tb_clk;
    logic       n_rst;
    logic       w_enable;
    logic [7:0] w_data;
    logic       r_enable;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
`ifdef RX_FIFO_ERROR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;

    rx_fifo #(.DEPTH(8), .DATA_WIDTH(8)) dut (
        .clk      (tb_clk),
        .n_rst    (n_rst),
        .w_enable (w_enable),
        .w_data   (w_data),
        .r_enable (r_enable),
        .r_data   (r_data),
        .empty    (empty),
`ifdef RX_FIFO_ERROR_FLAGS_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .full     (full)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // One rising edge, then settle 1 time unit before sampling or driving.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle_inputs();
        n_rst    = 1'b0;
        w_enable = 1'b0;
        r_enable = 1'b0;
        w_data   = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            vec_cnt++;
            if (empty !== 1'b1) begin miss_cnt++; $display("FAIL reset_empty[%0d]: got %b want 1", k, empty); end
            vec_cnt++;
            if (full !== 1'b0) begin miss_cnt++; $display("FAIL reset_full[%0d]: got %b want 0", k, full); end
            vec_cnt++;
            if (r_data !== 8'h00) begin miss_cnt++; $display("FAIL reset_rdata[%0d]: got %h want 00", k, r_data); end
`ifdef RX_FIFO_ERROR_FLAGS_EN
            vec_cnt++;
            if ({overflow, underflow} !== 2'b00) begin miss_cnt++; $display("FAIL reset_flags[%0d]: got %b want 00", k, {overflow, underflow}); end
`endif
            step();
        end
    endtask

    task automatic test_fill();
        do_reset();
        w_enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            w_data = 8'(i);
            step();
            vec_cnt++;
            if (full !== (i >= 8)) begin miss_cnt++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i >= 8)); end
            vec_cnt++;
            if (empty !== 1'b0) begin miss_cnt++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
            vec_cnt++;
            if (r_data !== 8'h01) begin miss_cnt++; $display("FAIL fill_head[%0d]: got %h want 01", i, r_data); end
`ifdef RX_FIFO_ERROR_FLAGS_EN
            vec_cnt++;
            if (overflow !== (i == 9)) begin miss_cnt++; $display("FAIL fill_overflow[%0d]: got %b want %b", i, overflow, (i == 9)); end
`endif
        end
        w_enable = 1'b0;
    endtask

    // Runs straight after test_fill: FIFO holds 01..08.
    task automatic test_drain();
        r_enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            vec_cnt++;
            if (r_data !== ((i <= 8) ? 8'(i) : 8'h00)) begin miss_cnt++; $display("FAIL drain_data[%0d]: got %h want %h", i, r_data, ((i <= 8) ? 8'(i) : 8'h00)); end
            step();
            vec_cnt++;
            if (empty !== (i >= 8)) begin miss_cnt++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty, (i >= 8)); end
            vec_cnt++;
            if (full !== 1'b0) begin miss_cnt++; $display("FAIL drain_full[%0d]: got %b want 0", i, full); end
`ifdef RX_FIFO_ERROR_FLAGS_EN
            vec_cnt++;
            if (underflow !== (i == 9)) begin miss_cnt++; $display("FAIL drain_underflow[%0d]: got %b want %b", i, underflow, (i == 9)); end
`endif
        end
        r_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        w_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_data = 8'h10 + 8'(i);
            step();
        end
        r_enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w_data = 8'h13 + 8'(k);
            vec_cnt++;
            if (r_data !== 8'h10 + 8'(k)) begin miss_cnt++; $display("FAIL b2b_data[%0d]: got %h want %h", k, r_data, 8'h10 + 8'(k)); end
            step();
            vec_cnt++;
            if ({empty, full} !== 2'b00) begin miss_cnt++; $display("FAIL b2b_flags[%0d]: got %b want 00", k, {empty, full}); end
        end
        w_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vec_cnt++;
            if (r_data !== 8'h1A + 8'(k)) begin miss_cnt++; $display("FAIL b2b_tail[%0d]: got %h want %h", k, r_data, 8'h1A + 8'(k)); end
            step();
        end
        r_enable = 1'b0;
        vec_cnt++;
        if (empty !== 1'b1) begin miss_cnt++; $display("FAIL b2b_end_empty: got %b want 1", empty); end
    endtask

    task automatic test_simul_edges();
        do_reset();
        w_enable = 1'b1;
        r_enable = 1'b1;
        w_data   = 8'hA5;
        step();
        r_enable = 1'b0;
        vec_cnt++;
        if (empty !== 1'b0) begin miss_cnt++; $display("FAIL se_empty_wr: got %b want 0", empty); end
        vec_cnt++;
        if (r_data !== 8'hA5) begin miss_cnt++; $display("FAIL se_empty_data: got %h want a5", r_data); end
`ifdef RX_FIFO_ERROR_FLAGS_EN
        vec_cnt++;
        if ({overflow, underflow} !== 2'b01) begin miss_cnt++; $display("FAIL se_underflow: got %b want 01", {overflow, underflow}); end
`endif
        for (int i = 0; i < 7; i++) begin
            w_data = 8'hB0 + 8'(i);
            step();
        end
        vec_cnt++;
        if (full !== 1'b1) begin miss_cnt++; $display("FAIL se_full: got %b want 1", full); end
        r_enable = 1'b1;
        w_data   = 8'hA5;
        step();
        w_enable = 1'b0;
        vec_cnt++;
        if (full !== 1'b0) begin miss_cnt++; $display("FAIL se_full_rd: got %b want 0", full); end
`ifdef RX_FIFO_ERROR_FLAGS_EN
        vec_cnt++;
        if (overflow !== 1'b1) begin miss_cnt++; $display("FAIL se_overflow: got %b want 1", overflow); end
`endif
        for (int i = 0; i < 7; i++) begin
            vec_cnt++;
            if (r_data !== 8'hB0 + 8'(i)) begin miss_cnt++; $display("FAIL se_drain[%0d]: got %h want %h", i, r_data, 8'hB0 + 8'(i)); end
            step();
        end
        r_enable = 1'b0;
        vec_cnt++;
        if (empty !== 1'b1) begin miss_cnt++; $display("FAIL se_no_extra: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        w_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_data = 8'h60 + 8'(i);
            step();
        end
        n_rst  = 1'b1;
        w_data = 8'h77;
        step();
        idle_inputs();
        vec_cnt++;
        if ({empty, full} !== 2'b10) begin miss_cnt++; $display("FAIL rmid_flags: got %b want 10", {empty, full}); end
        vec_cnt++;
        if (r_data !== 8'h00) begin miss_cnt++; $display("FAIL rmid_data: got %h want 00", r_data); end
        step();
        vec_cnt++;
        if (empty !== 1'b1) begin miss_cnt++; $display("FAIL rmid_idle_empty: got %b want 1", empty); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic       m_ovf;
        logic       m_udf;
        logic       w_acc;
        logic       r_acc;
        do_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            n_rst    = ($urandom_range(0, 59) == 0);
            w_enable = $urandom_range(0, 1) == 1;
            r_enable = $urandom_range(0, 1) == 1;
            w_data   = 8'($urandom_range(0, 255));
            #1;
            vec_cnt++;
            if (empty !== (q.size() == 0)) begin miss_cnt++; $display("FAIL rnd_empty[%0d]: got %b want %b", c, empty, (q.size() == 0)); end
            vec_cnt++;
            if (full !== (q.size() == 8)) begin miss_cnt++; $display("FAIL rnd_full[%0d]: got %b want %b", c, full, (q.size() == 8)); end
            vec_cnt++;
            if (r_data !== ((q.size() == 0) ? 8'h00 : q[0])) begin miss_cnt++; $display("FAIL rnd_data[%0d]: got %h want %h", c, r_data, ((q.size() == 0) ? 8'h00 : q[0])); end
`ifdef RX_FIFO_ERROR_FLAGS_EN
            vec_cnt++;
            if ({overflow, underflow} !== {m_ovf, m_udf}) begin miss_cnt++; $display("FAIL rnd_flags[%0d]: got %b want %b", c, {overflow, underflow}, {m_ovf, m_udf}); end
`endif
            if (n_rst) begin
                q.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                w_acc = w_enable && (q.size() < 8);
                r_acc = r_enable && (q.size() > 0);
                if (w_enable && !w_acc) m_ovf = 1'b1;
                if (r_enable && !r_acc) m_udf = 1'b1;
                if (r_acc) void'(q.pop_front());
                if (w_acc) q.push_back(w_data);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simul_edges();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of storage entries; it must be a power of two and at least 2.
REQ-003 Parameter DATA_WIDTH, default 8, SHALL set the width of each entry.
REQ-004 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 n_rst  input  1  SHALL be the synchronous reset; active-high, so n_rst=1 at a rising edge resets.
REQ-006 w_enable  input  1  SHALL be the write request for the current cycle.
REQ-007 w_data  input  DATA_WIDTH  SHALL be the data captured on an accepted write.
REQ-008 r_enable  input  1  SHALL be the read (pop) request for the current cycle.
REQ-009 r_data  output  DATA_WIDTH  SHALL present the oldest stored entry (first-word fall-through).
REQ-010 empty  output  1  SHALL be high when the occupancy is 0.
REQ-011 full  output  1  SHALL be high when the occupancy equals DEPTH.

Function
REQ-012 Storage SHALL be a circular buffer of DEPTH entries with write pointer, read pointer (log2(DEPTH) bits each, wrapping DEPTH-1 -> 0) and an occupancy count 0..DEPTH.
REQ-013 A write SHALL be accepted when w_enable=1 and full=0: w_data stored at the write pointer, pointer +1.
REQ-014 A read SHALL be accepted when r_enable=1 and empty=0: read pointer +1, discarding the head entry.
REQ-015 w_enable=1 while full=1 SHALL be ignored, even if a read is accepted in the same cycle.
REQ-016 r_enable=1 while empty=1 SHALL be ignored, even if a write is accepted in the same cycle.
REQ-017 Simultaneous accepted read and write SHALL both take effect, with the count unchanged.
REQ-018 The count SHALL change by +1 on write only, -1 on read only, and 0 otherwise.
REQ-019 empty and full SHALL be decoded from the registered count, so they update in the same cycle as the clock edge that changes the count.
REQ-020 r_data SHALL equal the entry at the read pointer combinationally when empty=0, and SHALL be all zeros when empty=1.
REQ-021 Data written SHALL be read back in the same order with no loss or duplication across pointer wrap-around.
REQ-022 Latency SHALL be one cycle: data written at edge N is visible on r_data after edge N if the FIFO was empty.

Reset
REQ-023 When n_rst=1 at a rising edge, the block SHALL clear both pointers, the count and all storage entries to 0, giving empty=1, full=0 and r_data=0.
REQ-024 Reset SHALL take priority over any simultaneous read or write, including reset asserted mid-operation.
REQ-025 The block SHALL have no asynchronous state change; outputs before the first reset edge are undefined.

Configuration
REQ-026 With macro RX_FIFO_ERROR_FLAGS_EN defined, the block SHALL add outputs overflow (1 bit) and underflow (1 bit).
REQ-027 With RX_FIFO_ERROR_FLAGS_EN defined, overflow SHALL be set by an ignored write (REQ-015) and underflow SHALL be set by an ignored read (REQ-016).
REQ-028 With RX_FIFO_ERROR_FLAGS_EN defined, both flags SHALL be sticky until reset, and reset SHALL clear them to 0.
REQ-029 Without RX_FIFO_ERROR_FLAGS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then idle: empty=1, full=0, r_data=8'h00.
REQ-031 Hold w_enable=1 for 9+ cycles with w_data=8'h01..8'h09: full=1 after the 8th edge, and the 9th write is dropped (overflow=1 if enabled).
REQ-032 From full, hold r_enable=1 for 9+ cycles: r_data sequence 8'h01..8'h08, empty=1 after the 8th edge, and the extra read is ignored (underflow=1 if enabled).
REQ-033 With count=3, assert w_enable=1 and r_enable=1 for 10 cycles: count stays 3, order is preserved and pointers wrap.
REQ-034 When empty, assert w_enable=1 and r_enable=1 with w_data=8'hA5: the write is accepted, empty=0 and r_data=8'hA5; when full, the same stimulus performs a read only.
REQ-035 Assert n_rst=1 with count=5 and w_enable=1: after the edge, empty=1 and the write is lost; then 1000+ random cycles of n_rst, r_enable, w_enable and w_data must match a reference queue model.
